console_uart_tx: RTL and testbench
==================================

CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the console write data bus.
REQ-002 Parameter CLKS_PER_BIT, default 16, minimum 2, SHALL set the number of clk cycles per UART bit.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two and at least 2, SHALL set the number of buffered bytes.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 console_we  input  1  one-cycle console write strobe, driven by the core's memory-mapped console port.
REQ-007 console_wdata  input  XLEN  console write data; only bits [7:0] SHALL be used.
REQ-008 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted.
REQ-011 overflow  output  1  sticky flag; high once any write has been dropped.

Function
REQ-012 The FIFO SHALL accept console_wdata[7:0] on any cycle where console_we=1 and either fifo_count<FIFO_DEPTH or a pop occurs in the same cycle.
REQ-013 A write with fifo_count==FIFO_DEPTH and no same-cycle pop SHALL be dropped, and overflow SHALL be set at the next edge.
REQ-014 overflow SHALL remain set until reset; no other condition SHALL clear it.
REQ-015 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-016 In IDLE with fifo_count>0, the FSM SHALL pop the head byte into the shift register and enter START at the same edge.
REQ-017 tx SHALL be a registered output: 1 in IDLE, 0 in START, shift_reg[0] in DATA, 1 in STOP.
REQ-018 A bit counter SHALL count CLKS_PER_BIT cycles for each bit period: START for 1 bit, DATA for 8 bits (right shift after each), STOP for 1 bit.
REQ-019 A full frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-020 At the final cycle of STOP with fifo_count>0, the FSM SHALL pop and enter START directly, with no idle gap between frames.
REQ-021 At the final cycle of STOP with an empty FIFO, the FSM SHALL return to IDLE.
REQ-022 Latency: a write at edge k into an empty FIFO with the FSM in IDLE SHALL make tx fall at edge k+1.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve byte order.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 console_wdata[XLEN-1:8] SHALL be ignored.

Reset
REQ-026 While reset=0, the block SHALL force: tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, counters=0, pointers=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued bytes.
REQ-028 After reset deasserts, no frame SHALL start until a new console write is accepted.

Verification
REQ-029 Single write of 0x00000041 with CLKS_PER_BIT=4 -> tx low at k+1; bits 1,0,0,0,0,0,1,0 at 4 cycles each; stop high; busy low at k+41.
REQ-030 Writes of 0x31, 0x32, 0x33 on consecutive cycles -> three frames back-to-back, 120 cycles total, order 31,32,33, no idle gap.
REQ-031 Six consecutive writes with FIFO_DEPTH=4 -> the first byte is popped at once, four more are queued, the sixth is dropped; overflow=1; five frames are transmitted.
REQ-032 Write on the final STOP cycle while the FIFO holds FIFO_DEPTH bytes -> the write is accepted via same-cycle pop; fifo_count stays FIFO_DEPTH; overflow stays 0.
REQ-033 Reset pulsed during the DATA bit 3 -> tx=1 and fifo_count=0 immediately; overflow cleared; the line stays idle until the next write.
REQ-034 Write of 0xDEADBE55 -> the transmitted byte is 0x55 only.

Source files
------------

// File: rtl/console_uart_tx_if.sv
// Console write port: a one-cycle write strobe plus its data word.
interface console_uart_tx_if #(
    parameter int XLEN = 32
);
    logic            we;
    logic [XLEN-1:0] wdata;

    modport master (output we, output wdata);
    modport slave  (input  we, input  wdata);
endinterface

// File: rtl/console_uart_tx.sv
// Console byte sink: queues the low byte of each console write in a small FIFO
// and shifts it out as an 8N1 UART frame, LSB first, back-to-back when queued.
module console_uart_tx #(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    console_uart_tx_if.slave              cons,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            tx_reg, tx_next;
    logic [AW:0]     count_reg;
    logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic            overflow_reg;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic            console_we;
    logic [XLEN-1:0] console_wdata;
    logic            unused_upper;
    logic            pop, push, bit_done, fifo_nonempty;
    logic [7:0]      head_byte;

    assign console_we    = cons.we;
    assign console_wdata = cons.wdata;
    assign unused_upper  = ^console_wdata[XLEN-1:8];

    assign fifo_nonempty = (count_reg != '0);
    assign head_byte     = fifo_mem[rd_ptr_reg];
    assign bit_done      = (clk_cnt_reg == CLK_LAST);
    // A full FIFO still takes a write when the same edge frees a slot.
    assign push          = console_we && ((count_reg != DEPTH) || pop);

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop          = 1'b1;
                    shift_next   = head_byte;
                    clk_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        shift_next = head_byte;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is registered, so it follows the state being entered.
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= console_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            count_reg   <= count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (console_we && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign tx         = tx_reg;
    assign busy       = (state_reg != IDLE) || fifo_nonempty;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: a frame-timing model checks every cycle, and
// directed scenarios pin decoded bytes and flag values with literal expectations.
module tb_console_uart_tx;
    localparam int C     = 4;
    localparam int D     = 4;
    localparam int XL    = 32;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    console_uart_tx_if #(.XLEN(XL)) cif ();

    console_uart_tx #(.XLEN(XL), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .cons       (cif.slave),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a queue of pending bytes and the position within the current frame.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    task automatic model_step();
        bit pop, push_ok;
        if (!reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            pop     = (m_q.size() > 0) && (!m_active || m_t == FRAME - 1);
            push_ok = cif.we && ((m_q.size() < D) || pop);
            if (cif.we && !push_ok) m_ovf = 1'b1;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 1'b0;
            end
            if (pop) begin
                m_cur    = m_q.pop_front();
                m_active = 1'b1;
                m_t      = 0;
                $display("frame start: byte %02h, %0d queued", m_cur, m_q.size());
            end
            if (push_ok) m_q.push_back(cif.wdata[7:0]);
        end
    endtask

    function automatic bit model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    bit tx_hist[$];
    bit busy_hist[$];

    initial forever begin
        @(negedge clk);
        tx_hist.push_back(tx);
        busy_hist.push_back(busy);
        check("cyc_tx", int'(tx), int'(model_tx()));
        check("cyc_busy", int'(busy), int'(m_active || m_q.size() > 0));
        check("cyc_count", int'(fifo_count), m_q.size());
        check("cyc_overflow", int'(overflow), int'(m_ovf));
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Returns just after the edge that takes the write; result is that cycle's history index.
    task automatic wr(input logic [31:0] d, output int ik);
        cif.we    = 1'b1;
        cif.wdata = d;
        cyc(1);
        cif.we = 1'b0;
        ik = tx_hist.size() - 1;
    endtask

    function automatic logic [7:0] decode(int s0);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tx_hist[s0 + C + C*j + C/2];
        return b;
    endfunction

    initial begin
        int ik;
        int pct;
        logic [7:0] exp_b;
        cif.we    = 1'b0;
        cif.wdata = '0;
        cyc(3);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_overflow", int'(overflow), 0);
        reset = 1'b1;
        cyc(2);

        // Single byte 0x41: start low at k+1, busy drops at k+41.
        wr(32'h0000_0041, ik);
        check("a_count", int'(fifo_count), 1);
        cyc(41);
        check("a_start_first", int'(tx_hist[ik+1]), 0);
        check("a_start_last", int'(tx_hist[ik+4]), 0);
        check("a_byte", int'(decode(ik+1)), 'h41);
        check("a_stop", int'(tx_hist[ik+37] & tx_hist[ik+40]), 1);
        check("a_busy_k40", int'(busy_hist[ik+40]), 1);
        check("a_busy_k41", int'(busy_hist[ik+41]), 0);

        // Three consecutive writes: frames back-to-back, 120 cycles.
        cif.we = 1'b1;
        cif.wdata = 32'h31; cyc(1);
        ik = tx_hist.size() - 1;
        cif.wdata = 32'h32; cyc(1);
        cif.wdata = 32'h33; cyc(1);
        cif.we = 1'b0;
        cyc(122);
        check("b_byte0", int'(decode(ik+1)), 'h31);
        check("b_byte1", int'(decode(ik+41)), 'h32);
        check("b_byte2", int'(decode(ik+81)), 'h33);
        check("b_nogap1", int'(tx_hist[ik+41]), 0);
        check("b_nogap2", int'(tx_hist[ik+81]), 0);
        check("b_busy_k120", int'(busy_hist[ik+120]), 1);
        check("b_busy_k121", int'(busy_hist[ik+121]), 0);

        // Upper data bits are ignored.
        wr(32'hDEAD_BE55, ik);
        cyc(42);
        check("c_byte", int'(decode(ik+1)), 'h55);

        // Six writes into a depth-4 FIFO: sixth dropped.
        cif.we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cif.wdata = 32'hA0 + i;
            cyc(1);
            if (i == 0) ik = tx_hist.size() - 1;
        end
        cif.we = 1'b0;
        check("d_count_full", int'(fifo_count), 4);
        check("d_overflow", int'(overflow), 1);
        cyc(5 * FRAME + 5);
        for (int n = 0; n < 5; n++) check("d_byte", int'(decode(ik + 1 + FRAME*n)), 'hA0 + n);
        check("d_busy_end", int'(busy), 0);
        check("d_overflow_sticky", int'(overflow), 1);

        reset = 1'b0;
        cyc(2);
        check("e_overflow_rst", int'(overflow), 0);
        reset = 1'b1;
        cyc(2);

        // Full FIFO plus a write on the last stop cycle: taken via same-edge pop.
        cif.we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cif.wdata = 32'hB0 + i;
            cyc(1);
            if (i == 0) ik = tx_hist.size() - 1;
        end
        cif.we = 1'b0;
        cyc(36);
        cif.we = 1'b1;
        cif.wdata = 32'hC5;
        cyc(1);
        cif.we = 1'b0;
        check("e_count_kept", int'(fifo_count), 4);
        check("e_overflow_clear", int'(overflow), 0);
        check("e_restart", int'(tx), 0);
        cyc(5 * FRAME + 5);
        check("e_byte_last", int'(decode(ik + 1 + 5*FRAME)), 'hC5);

        // Reset in the middle of data bit 3 with a full FIFO and overflow set.
        cif.we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cif.wdata = 32'hE0 + i;
            cyc(1);
        end
        cif.we = 1'b0;
        cyc(13);
        reset = 1'b0;
        #1;
        check("f_tx_rst", int'(tx), 1);
        check("f_count_rst", int'(fifo_count), 0);
        check("f_overflow_rst", int'(overflow), 0);
        check("f_busy_rst", int'(busy), 0);
        cyc(1);
        reset = 1'b1;
        cyc(50);
        check("f_tx_idle", int'(tx), 1);
        check("f_busy_idle", int'(busy), 0);

        // Random traffic with varying write density and occasional resets.
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0: pct = 3;
                1: pct = 15;
                default: pct = 60;
            endcase
            for (int n = 0; n < 300; n++) begin
                cif.we    = ($urandom_range(0, 99) < pct);
                cif.wdata = $urandom;
                if ($urandom_range(0, 599) == 0) reset = 1'b0;
                cyc(1);
                reset = 1'b1;
            end
        end
        cif.we = 1'b0;
        cyc(6 * FRAME);
        check("r_drained", int'(busy), 0);

        exp_b = 8'h5A;
        wr({24'hFFFFFF, exp_b}, ik);
        cyc(42);
        check("r_final_byte", int'(decode(ik+1)), 'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
